// File: rtl/gtech_fjk_bank.sv
// gtech_fjk_bank
//   A bank of WIDTH JK flip-flops sharing one clock, with a synchronous
//   reset, a parallel load and four per-edge operating modes.
//
//   Parameters
//     WIDTH      number of channels (1..32)
//     RESET_VAL  value Q takes when CD is sampled high
//
//   Ports
//     CP    clock; every state update happens on its rising edge
//     CD    synchronous active-high reset (highest priority)
//     EN    update enable for the JK / toggle / count modes
//     MODE  00 JK, 01 toggle, 10 count up, 11 count down
//     J, K  per-channel JK inputs (J doubles as T in toggle mode)
//     LD    parallel load strobe, beats EN
//     D     parallel load data
//     Q     registered state, QN its inverse
//     TC    combinational terminal count for the active count direction
//     CHG   registered flag: Q changed on the previous edge
module gtech_fjk_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             CP,
    input  logic             CD,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QN,
    output logic             TC,
    output logic             CHG
);

    localparam logic [1:0] MODE_JK   = 2'b00;
    localparam logic [1:0] MODE_T    = 2'b01;
    localparam logic [1:0] MODE_UP   = 2'b10;
    localparam logic [1:0] MODE_DOWN = 2'b11;

    logic [WIDTH-1:0] q_q, q_d;
    logic             chg_q, chg_d;

    logic [WIDTH-1:0] low_mask;
    logic [WIDTH-1:0] up_t, dn_t;
    logic [WIDTH-1:0] j_eff, k_eff;
    logic [WIDTH-1:0] jk_next;

    // Every mode is reduced to an effective J/K pair per bit, so all four
    // modes go through the same JK next-state equation. The counters are a
    // synchronous cascade: bit i toggles when every bit below it is 1 (up)
    // or 0 (down); the lower-bit test is a masked reduction rather than a
    // ripple chain so no bit depends on a neighbour's toggle term.
    always_comb begin
        low_mask = '0;
        up_t     = '0;
        dn_t     = '0;
        j_eff    = '0;
        k_eff    = '0;
        jk_next  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            low_mask = (WIDTH'(1) << i) - WIDTH'(1);
            up_t[i]  = &(q_q | ~low_mask);
            dn_t[i]  = ~|(q_q & low_mask);
            case (MODE)
                MODE_JK: begin
                    j_eff[i] = J[i];
                    k_eff[i] = K[i];
                end
                MODE_T: begin
                    j_eff[i] = J[i];
                    k_eff[i] = J[i];
                end
                MODE_UP: begin
                    j_eff[i] = up_t[i];
                    k_eff[i] = up_t[i];
                end
                default: begin
                    j_eff[i] = dn_t[i];
                    k_eff[i] = dn_t[i];
                end
            endcase
            jk_next[i] = (j_eff[i] & ~q_q[i]) | (~k_eff[i] & q_q[i]);
        end
    end

    // Load beats enable; reset is applied in the register itself.
    always_comb begin
        q_d = q_q;
        if (LD) begin
            q_d = D;
        end else if (EN) begin
            q_d = jk_next;
        end
        chg_d = (q_d != q_q);
    end

    always_ff @(posedge CP) begin
        if (CD) begin
            q_q   <= RESET_VAL;
            chg_q <= (q_q != RESET_VAL);
        end else begin
            q_q   <= q_d;
            chg_q <= chg_d;
        end
    end

    // TC looks only at EN, MODE and Q so that a pending load or reset does
    // not mask it.
    always_comb begin
        TC = 1'b0;
        if (EN) begin
            if (MODE == MODE_UP) begin
                TC = &q_q;
            end else if (MODE == MODE_DOWN) begin
                TC = ~|q_q;
            end
        end
    end

    assign Q   = q_q;
    assign QN  = ~q_q;
    assign CHG = chg_q;

endmodule

// File: tb/tb_gtech_fjk_bank.sv
module tb_gtech_fjk_bank;

    logic       CP = 1'b0;
    logic       cd, en, ld;
    logic [1:0] mode;

    logic [7:0]  j8, k8, d8;
    logic [7:0]  q8, qn8;
    logic        tc8, chg8;

    logic [0:0]  j1, k1, d1;
    logic [0:0]  q1, qn1;
    logic        tc1, chg1;

    logic [31:0] j32, k32, d32;
    logic [31:0] q32, qn32;
    logic        tc32, chg32;

    localparam logic [0:0]  RV1  = 1'b1;
    localparam logic [31:0] RV32 = 32'hA5C3_0F96;

    always #5 CP = ~CP;

    gtech_fjk_bank #(.WIDTH(8), .RESET_VAL(8'h00)) u_dut8 (
        .CP(CP), .CD(cd), .EN(en), .MODE(mode), .J(j8), .K(k8), .LD(ld), .D(d8),
        .Q(q8), .QN(qn8), .TC(tc8), .CHG(chg8));

    gtech_fjk_bank #(.WIDTH(1), .RESET_VAL(RV1)) u_dut1 (
        .CP(CP), .CD(cd), .EN(en), .MODE(mode), .J(j1), .K(k1), .LD(ld), .D(d1),
        .Q(q1), .QN(qn1), .TC(tc1), .CHG(chg1));

    gtech_fjk_bank #(.WIDTH(32), .RESET_VAL(RV32)) u_dut32 (
        .CP(CP), .CD(cd), .EN(en), .MODE(mode), .J(j32), .K(k32), .LD(ld), .D(d32),
        .Q(q32), .QN(qn32), .TC(tc32), .CHG(chg32));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: behaviour written directly from the mode rules.
    function automatic logic [31:0] width_mask(input int w);
        return (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    function automatic logic [31:0] ref_next(input int w, input logic [31:0] q,
                                             input logic c, input logic l, input logic e,
                                             input logic [1:0] m, input logic [31:0] j,
                                             input logic [31:0] k, input logic [31:0] d,
                                             input logic [31:0] rv);
        logic [31:0] mk, n;
        mk = width_mask(w);
        if (c) return rv & mk;
        if (l) return d & mk;
        if (!e) return q;
        n = q;
        case (m)
            2'd0: for (int b = 0; b < w; b++) begin
                case ({j[b], k[b]})
                    2'b00: n[b] = q[b];
                    2'b01: n[b] = 1'b0;
                    2'b10: n[b] = 1'b1;
                    default: n[b] = ~q[b];
                endcase
            end
            2'd1: n = q ^ (j & mk);
            2'd2: n = (q + 32'd1) & mk;
            default: n = (q - 32'd1) & mk;
        endcase
        return n;
    endfunction

    function automatic logic ref_tc(input int w, input logic [31:0] q, input logic e,
                                    input logic [1:0] m);
        return e && ((m == 2'd2 && q == width_mask(w)) || (m == 2'd3 && q == 32'd0));
    endfunction

    logic [31:0] mq1, mq8, mq32;
    logic        valid = 1'b0;
    logic        tc8_pre;

    // One clock edge: check TC before the edge, Q/QN/CHG after it, on all
    // three instances.
    task automatic step();
        logic [31:0] n1, n8, n32;
        logic        had_valid;
        @(negedge CP);
        tc8_pre = tc8;
        if (valid) begin
            check("tc_w8",  {31'b0, tc8},  {31'b0, ref_tc(8,  mq8,  en, mode)});
            check("tc_w1",  {31'b0, tc1},  {31'b0, ref_tc(1,  mq1,  en, mode)});
            check("tc_w32", {31'b0, tc32}, {31'b0, ref_tc(32, mq32, en, mode)});
        end
        n8  = ref_next(8,  mq8,  cd, ld, en, mode, {24'b0, j8}, {24'b0, k8}, {24'b0, d8}, 32'h0);
        n1  = ref_next(1,  mq1,  cd, ld, en, mode, {31'b0, j1}, {31'b0, k1}, {31'b0, d1}, {31'b0, RV1});
        n32 = ref_next(32, mq32, cd, ld, en, mode, j32, k32, d32, RV32);
        @(posedge CP);
        #1;
        had_valid = valid;
        if (valid || cd) begin
            check("q_w8",   {24'b0, q8},   n8);
            check("qn_w8",  {24'b0, qn8},  ~n8 & 32'hFF);
            check("q_w1",   {31'b0, q1},   n1);
            check("qn_w1",  {31'b0, qn1},  ~n1 & 32'h1);
            check("q_w32",  q32,           n32);
            check("qn_w32", qn32,          ~n32);
        end
        if (had_valid) begin
            check("chg_w8",  {31'b0, chg8},  {31'b0, n8  != mq8});
            check("chg_w1",  {31'b0, chg1},  {31'b0, n1  != mq1});
            check("chg_w32", {31'b0, chg32}, {31'b0, n32 != mq32});
        end
        mq8 = n8; mq1 = n1; mq32 = n32;
        if (cd) valid = 1'b1;
    endtask

    typedef struct {
        logic       cd, ld, en;
        logic [1:0] mode;
        logic [7:0] j, k, d;
        logic [7:0] exp_q;
        logic       exp_chg;
        logic       exp_tc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic c, input logic l, input logic e, input logic [1:0] m,
                                input logic [7:0] j, input logic [7:0] k, input logic [7:0] d,
                                input logic [7:0] eq, input logic ec, input logic et);
        vec_t v;
        v.cd = c; v.ld = l; v.en = e; v.mode = m; v.j = j; v.k = k; v.d = d;
        v.exp_q = eq; v.exp_chg = ec; v.exp_tc = et;
        return v;
    endfunction

    task automatic drive8(input logic c, input logic l, input logic e, input logic [1:0] m,
                          input logic [7:0] j, input logic [7:0] k, input logic [7:0] d);
        cd = c; ld = l; en = e; mode = m;
        j8 = j; k8 = k; d8 = d;
        j1 = j[0]; k1 = k[0]; d1 = d[0];
        j32 = {4{j}}; k32 = {4{k}}; d32 = {d, ~d, d, 8'h5A};
    endtask

    initial begin
        drive8(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);

        //          cd ld en mode  J      K      D      Q      CHG  TC(pre-edge)
        tbl.push_back(mk(0, 0, 1, 2'd0, 8'hF0, 8'h0F, 8'h00, 8'hF0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 2'd0, 8'hF0, 8'h0F, 8'h00, 8'hF0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 2'd0, 8'hFF, 8'hFF, 8'h00, 8'h0F, 1, 0));
        tbl.push_back(mk(0, 1, 1, 2'd2, 8'h00, 8'h00, 8'hFE, 8'hFE, 1, 0));
        tbl.push_back(mk(0, 0, 1, 2'd2, 8'h00, 8'h00, 8'h00, 8'hFF, 1, 0));
        tbl.push_back(mk(0, 0, 1, 2'd2, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1));
        tbl.push_back(mk(0, 0, 1, 2'd3, 8'h00, 8'h00, 8'h00, 8'hFF, 1, 1));
        tbl.push_back(mk(0, 1, 0, 2'd3, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0));
        tbl.push_back(mk(0, 0, 0, 2'd3, 8'hFF, 8'hFF, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 1, 2'd1, 8'hAA, 8'h55, 8'h00, 8'hAA, 1, 0));
        tbl.push_back(mk(0, 0, 1, 2'd1, 8'hAA, 8'h55, 8'h00, 8'h00, 1, 0));
        tbl.push_back(mk(0, 0, 0, 2'd1, 8'hAA, 8'h55, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 0, 2'd0, 8'h00, 8'h00, 8'hFF, 8'hFF, 1, 0));
        tbl.push_back(mk(0, 1, 1, 2'd2, 8'h00, 8'h00, 8'h3C, 8'h3C, 1, 1));
        tbl.push_back(mk(0, 1, 1, 2'd2, 8'h00, 8'h00, 8'h10, 8'h10, 1, 0));
        tbl.push_back(mk(0, 0, 1, 2'd2, 8'h00, 8'h00, 8'h00, 8'h11, 1, 0));
        tbl.push_back(mk(1, 1, 1, 2'd2, 8'h00, 8'h00, 8'h55, 8'h00, 1, 0));
        tbl.push_back(mk(0, 1, 0, 2'd2, 8'h00, 8'h00, 8'h55, 8'h55, 1, 0));
        tbl.push_back(mk(0, 1, 1, 2'd3, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0));
        tbl.push_back(mk(1, 0, 1, 2'd3, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1));

        // first reset: outputs before it are undefined
        step();
        step();

        foreach (tbl[i]) begin
            drive8(tbl[i].cd, tbl[i].ld, tbl[i].en, tbl[i].mode, tbl[i].j, tbl[i].k, tbl[i].d);
            step();
            check($sformatf("vec%0d_q", i),   {24'b0, q8},      {24'b0, tbl[i].exp_q});
            check($sformatf("vec%0d_chg", i), {31'b0, chg8},    {31'b0, tbl[i].exp_chg});
            check($sformatf("vec%0d_tc", i),  {31'b0, tc8_pre}, {31'b0, tbl[i].exp_tc});
        end

        // randomized regression across all three widths
        for (int n = 0; n < 3000; n++) begin
            int r;
            cd   = ($urandom_range(99) < 3);
            ld   = ($urandom_range(99) < 10);
            en   = ($urandom_range(99) < 75);
            mode = 2'($urandom_range(3));
            j8 = 8'($urandom); k8 = 8'($urandom);
            j1 = 1'($urandom); k1 = 1'($urandom); d1 = 1'($urandom);
            j32 = $urandom; k32 = $urandom;
            r = int'($urandom_range(3));
            case (r)
                0: begin d8 = 8'h00; d32 = 32'h0; end
                1: begin d8 = 8'hFF; d32 = 32'hFFFF_FFFF; end
                2: begin d8 = 8'hFE; d32 = 32'h0000_0001; end
                default: begin d8 = 8'($urandom); d32 = $urandom; end
            endcase
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

endmodule

// File: doc/gtech_fjk_bank.md
GTECH_FJK_BANK -- requirements
Module: gtech_fjk_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning number of JK flip-flop channels (legal range 1..32).
REQ-002 The block SHALL have parameter RESET_VAL, default 0, meaning the WIDTH-bit value Q takes on reset.
REQ-003 The block SHALL have port CP, input, 1 bit, the single clock; all state updates occur on the rising edge of CP.
REQ-004 The block SHALL have port CD, input, 1 bit, reset; reset is synchronous and active-high.
REQ-005 The block SHALL have port EN, input, 1 bit, the per-cycle update enable for JK/T/count operation.
REQ-006 The block SHALL have port MODE, input, 2 bits: 00 JK, 01 toggle (T), 10 count up, 11 count down.
REQ-007 The block SHALL have port J, input, WIDTH bits, per-channel J (also the T input in mode 01).
REQ-008 The block SHALL have port K, input, WIDTH bits, per-channel K (used in mode 00 only).
REQ-009 The block SHALL have port LD, input, 1 bit, the synchronous parallel-load strobe.
REQ-010 The block SHALL have port D, input, WIDTH bits, the parallel-load data.
REQ-011 The block SHALL have port Q, output, WIDTH bits, registered state.
REQ-012 The block SHALL have port QN, output, WIDTH bits, always the bitwise inverse of Q.
REQ-013 The block SHALL have port TC, output, 1 bit, combinational terminal count.
REQ-014 The block SHALL have port CHG, output, 1 bit, registered flag: Q changed on the previous CP edge.

Function
REQ-015 Per-edge priority SHALL be CD > LD > EN; with none asserted Q SHALL hold.
REQ-016 LD=1 (CD=0) SHALL load Q<=D on the edge regardless of EN and MODE.
REQ-017 Mode 00, EN=1: per bit i, {J[i],K[i]} = 00 hold, 01 clear, 10 set, 11 toggle.
REQ-018 Mode 01, EN=1: bit i SHALL toggle when J[i]=1 and hold when J[i]=0; K ignored.
REQ-019 Mode 10, EN=1: Q<=Q+1 modulo 2^WIDTH (all ones wraps to 0); J and K ignored.
REQ-020 Mode 11, EN=1: Q<=Q-1 modulo 2^WIDTH (0 wraps to all ones); J and K ignored.
REQ-021 The counter modes SHALL be implemented as a synchronous JK cascade: bit i toggles when EN=1 and all lower bits are 1 (up) or 0 (down); the result SHALL equal the arithmetic in REQ-019/020.
REQ-022 TC SHALL be 1 only when EN=1 and (MODE=10 with Q all ones, or MODE=11 with Q all zeros); otherwise 0; TC is independent of LD and CD.
REQ-023 CHG SHALL be registered 1 on an edge where the next Q differs from the current Q (any cause, including reset and load), else 0.
REQ-024 A MODE change SHALL take effect on the same edge it is sampled; no state is retained per mode.
REQ-025 Latency: Q reflects inputs sampled at edge n immediately after edge n; CHG is valid in the same cycle as the new Q.

Reset
REQ-026 CD=1 at a CP edge SHALL set Q<=RESET_VAL; QN is its inverse.
REQ-027 CHG after a reset edge SHALL be 1 if Q differed from RESET_VAL before the edge, else 0.
REQ-028 Reset SHALL override LD and EN on the same edge, including mid-count.
REQ-029 Outputs before the first reset edge are undefined; the bench SHALL check only after one reset.

Verification
REQ-030 WIDTH=8, reset, MODE=00, EN=1, J=0xF0, K=0x0F -> Q=0xF0, QN=0x0F, CHG=1; repeat edge -> Q=0xF0, CHG=0; then J=K=0xFF -> Q=0x0F.
REQ-031 MODE=10, EN=1, LD=1 D=0xFE, then 2 edges with LD=0 -> Q=0xFF with TC=1, then Q=0x00 with TC=0, CHG=1.
REQ-032 MODE=11, EN=1 from Q=0x00 -> TC=1 before the edge, Q=0xFF after; EN=0 -> TC=0, Q holds, CHG=0.
REQ-033 MODE=01, J=0xAA, EN=1 from Q=0x00 -> 0xAA, then 0x00; EN=0 -> no change.
REQ-034 Count up from 0x10, assert CD and LD (D=0x55) together -> Q=RESET_VAL (0x00), CHG=1; next edge LD only -> Q=0x55.
REQ-035 Random regression (WIDTH=1, 8, 32) against a reference model covering all modes, LD/EN/CD interleaving, and wrap at both ends.
